// File: rtl/gpio_result_reporter_pkg.sv
// gpio_report_pkg: shared definitions for the GPIO result reporter.
//   - phase codes driven on mprj_io[37:36]
//   - reporter FSM state type and FIFO entry layout
//   - error codes shown on the value field in the ERROR phase
//   - bit positions of the phase field inside io_out_o
package gpio_report_pkg;

  localparam logic [1:0] PH_IDLE    = 2'b00;
  localparam logic [1:0] PH_STARTED = 2'b01;
  localparam logic [1:0] PH_DATA    = 2'b10;
  localparam logic [1:0] PH_ERROR   = 2'b11;

  localparam logic [15:0] ERR_CODE_FATAL = 16'hDEAD;
  localparam logic [15:0] ERR_CODE_WDOG  = 16'hBEEF;

  localparam int unsigned PHASE_MSB = 17;
  localparam int unsigned PHASE_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ANNOUNCE,
    ST_WAIT,
    ST_DATA,
    ST_GAP,
    ST_ERROR
  } report_state_t;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } report_entry_t;

  function automatic logic [1:0] phase_of(input report_state_t s);
    case (s)
      ST_ANNOUNCE, ST_WAIT: phase_of = PH_STARTED;
      ST_DATA:              phase_of = PH_DATA;
      ST_ERROR:             phase_of = PH_ERROR;
      default:              phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_result_reporter_fifo.sv
// report_fifo: single-clock synchronous FIFO buffering result entries.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (empties the FIFO)
//   i_flush        discard all entries (same effect as reset, wins over push)
//   i_push/i_wdata write an entry; accepted when not full, or when full and
//                  a pop happens in the same cycle
//   i_pop          remove the head entry (ignored when empty)
//   o_rdata        head entry (valid while !o_empty)
//   o_full/o_empty occupancy flags
module report_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/gpio_result_reporter.sv
// gpio_result_reporter: presents buffered test result words on the user
// project status pins mprj_io[37:20] with stable hold/gap timing.
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   start_i              pulse, begins a report session (IDLE only)
//   res_valid_i/res_ready_o/res_data_i/res_last_i  result word stream
//   err_i                pulse, fatal error -> sticky ERROR phase
//   io_out_o             [17:16] phase, [15:0] value (registered)
//   io_oeb_o             pad output enables, all driven (0)
//   busy_o               session in progress
//   words_sent_o         data words presented this session (saturating)
// Optional: define GPIO_REPORTER_WATCHDOG_EN to abort a session that sits
// in WAIT for WDOG_CYCLES cycles (ERROR with value 16'hBEEF).
module gpio_result_reporter
  import gpio_report_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WDOG_CYCLES = 100000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  input  logic [15:0] res_data_i,
  input  logic        res_last_i,
  input  logic        err_i,
  output logic [17:0] io_out_o,
  output logic [17:0] io_oeb_o,
  output logic        busy_o,
  output logic [15:0] words_sent_o
);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WDOG_CYCLES < 1) begin : g_bad_params
    $error("gpio_result_reporter: invalid parameter set");
  end

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  report_state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  report_entry_t    r_word, w_head;
  logic [15:0]      r_err_code, w_err_code;
  logic [15:0]      r_words;
  logic [17:0]      r_io;
  logic             w_pop, w_push, w_flush, w_full, w_empty;

`ifdef GPIO_REPORTER_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
  logic [WDOG_W-1:0] r_wdog;

  // Held at zero outside WAIT, so every entry to WAIT starts a fresh count.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || r_state != ST_WAIT) r_wdog <= '0;
    else                                r_wdog <= r_wdog + WDOG_ONE;
  end
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_pop      = 1'b0;
    w_err_code = r_err_code;
    if (err_i && r_state != ST_ERROR) begin
      w_next     = ST_ERROR;
      w_err_code = ERR_CODE_FATAL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            w_next     = ST_ANNOUNCE;
            w_cnt_next = HOLD_LD;
          end
        end
        ST_ANNOUNCE: begin
          if (r_cnt == CNT_ONE) w_next = ST_WAIT;
          else                  w_cnt_next = r_cnt - CNT_ONE;
        end
        ST_WAIT: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_next     = ST_DATA;
            w_cnt_next = HOLD_LD;
          end
`ifdef GPIO_REPORTER_WATCHDOG_EN
          else if (r_wdog == WDOG_LAST) begin
            w_next     = ST_ERROR;
            w_err_code = ERR_CODE_WDOG;
          end
`endif
        end
        ST_DATA: begin
          if (r_cnt == CNT_ONE) begin
            w_next     = ST_GAP;
            w_cnt_next = GAP_LD;
          end else begin
            w_cnt_next = r_cnt - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (r_cnt == CNT_ONE) w_next = r_word.last ? ST_IDLE : ST_WAIT;
          else                  w_cnt_next = r_cnt - CNT_ONE;
        end
        ST_ERROR: w_next = ST_ERROR;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_flush     = (w_next == ST_ERROR);
  assign res_ready_o = (r_state != ST_ERROR) && (!w_full || w_pop);
  assign w_push      = res_valid_i && res_ready_o;

  report_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(17)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata ({res_last_i, res_data_i}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // io_out_o is derived from the current state, so it trails state entry by
  // one cycle and stays constant for the whole hold/gap window.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_word     <= '0;
      r_err_code <= ERR_CODE_FATAL;
      r_words    <= '0;
      r_io       <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_err_code <= w_err_code;
      if (w_pop) r_word <= w_head;
      if (r_state == ST_IDLE && w_next == ST_ANNOUNCE) r_words <= '0;
      else if (w_pop && r_words != '1)                 r_words <= r_words + 16'd1;
      case (r_state)
        ST_IDLE, ST_ANNOUNCE: r_io <= {phase_of(r_state), 16'h0000};
        ST_WAIT, ST_GAP:      r_io[PHASE_MSB:PHASE_LSB] <= phase_of(r_state);
        ST_DATA:              r_io <= {PH_DATA, r_word.data};
        ST_ERROR:             r_io <= {PH_ERROR, r_err_code};
        default:              r_io <= '0;
      endcase
    end
  end

  assign io_out_o     = r_io;
  assign io_oeb_o     = '0;
  assign busy_o       = (r_state == ST_ANNOUNCE) || (r_state == ST_WAIT) ||
                        (r_state == ST_DATA) || (r_state == ST_GAP);
  assign words_sent_o = r_words;

endmodule

// File: tb/tb_gpio_result_reporter.sv
// Testbench for gpio_result_reporter. The pin activity is compressed into
// (phase, value, length) segments and compared against the segment sequence
// a session must produce for the words the reporter accepted.
module tb_gpio_result_reporter;

  localparam int unsigned HOLD  = 64;
  localparam int unsigned GAP   = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BIG   = 1000000;
`ifdef GPIO_REPORTER_WATCHDOG_EN
  localparam int unsigned WDOG  = 200;
`else
  localparam int unsigned WDOG  = 100000;
`endif

  logic        clk = 1'b0;
  logic        rst, start, valid, last, err;
  logic [15:0] data;
  logic        ready, busy;
  logic [17:0] io_out, oeb;
  logic [15:0] words;

  always #5 clk = ~clk;

  gpio_result_reporter #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .FIFO_DEPTH (DEPTH),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start),
    .res_valid_i (valid),
    .res_ready_o (ready),
    .res_data_i  (data),
    .res_last_i  (last),
    .err_i       (err),
    .io_out_o    (io_out),
    .io_oeb_o    (oeb),
    .busy_o      (busy),
    .words_sent_o(words)
  );

  typedef struct {
    logic [1:0]  ph;
    logic [15:0] val;
    int unsigned len;
  } seg_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } word_t;

  seg_t        seg_q[$];
  word_t       tx_q[$];
  word_t       acc_q[$];
  bit          mon_en = 1'b0;
  int unsigned seg_k;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    seg_t s;
    if (mon_en) begin
      if (seg_q.size() != 0) s = seg_q[seg_q.size()-1];
      if (seg_q.size() != 0 && s.ph == io_out[17:16] && s.val == io_out[15:0]) begin
        s.len++;
        seg_q[seg_q.size()-1] = s;
      end else begin
        s.ph  = io_out[17:16];
        s.val = io_out[15:0];
        s.len = 1;
        seg_q.push_back(s);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; valid = 1'b0; err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_seq(input int unsigned n, input logic [15:0] base, input bit rnd);
    word_t w;
    for (int unsigned i = 0; i < n; i++) begin
      w.d = rnd ? 16'($urandom_range(16'hFFFF, 1)) : base + 16'(i);
      w.l = (i == n - 1);
      tx_q.push_back(w);
    end
  endtask

  task automatic push_one(input word_t w, input int unsigned gap);
    int unsigned c = 0;
    repeat (gap) @(negedge clk);
    valid = 1'b1; data = w.d; last = w.l;
    #1;
    while (ready !== 1'b1 && c < 3000) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("push_ready", ready, 1);
    @(negedge clk);
    valid = 1'b0;
    if (c < 3000) acc_q.push_back(w);
  endtask

  task automatic wait_io_phase(input string tag, input logic [1:0] ph);
    int unsigned c = 0;
    while (io_out[17:16] !== ph && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(tag, io_out[17:16], ph);
  endtask

  task automatic exp_seg(input string tag, input logic [1:0] ph, input logic [15:0] val,
                         input int unsigned lmin, input int unsigned lmax);
    seg_t s;
    check({tag, "_present"}, seg_q.size() > seg_k, 1);
    if (seg_q.size() <= seg_k) return;
    s = seg_q[seg_k];
    seg_k++;
    check({tag, "_phase"}, s.ph, ph);
    check({tag, "_value"}, s.val, val);
    if (lmin == lmax) check({tag, "_len"}, s.len, lmin);
    else              check({tag, "_len_in_range"}, (s.len >= lmin) && (s.len <= lmax), 1);
  endtask

  // Session shape: idle, STARTED (announce + first wait), then per word
  // DATA(hold) and GAP(gap) showing the word, a STARTED wait between words,
  // and idle with value 0 after the last word.
  task automatic verify_session();
    seg_k = 0;
    exp_seg("idle0", 2'b00, 16'h0000, 1, BIG);
    exp_seg("announce", 2'b01, 16'h0000, HOLD + 1, BIG);
    foreach (acc_q[i]) begin
      exp_seg("data", 2'b10, acc_q[i].d, HOLD, HOLD);
      exp_seg("gap", 2'b00, acc_q[i].d, GAP, GAP);
      if (i < acc_q.size() - 1) exp_seg("wait", 2'b01, acc_q[i].d, 1, BIG);
    end
    exp_seg("idle_end", 2'b00, 16'h0000, 1, BIG);
    check("seg_count", seg_q.size(), seg_k);
    check("words_sent", words, acc_q.size());
  endtask

  task automatic session(input int unsigned n_pre, input int unsigned gap_max, input bit chk_full);
    int unsigned c = 0;
    acc_q.delete();
    seg_q.delete();
    mon_en = 1'b1;
    for (int unsigned i = 0; i < n_pre; i++) push_one(tx_q.pop_front(), 0);
    if (chk_full && tx_q.size() != 0) begin
      valid = 1'b1; data = tx_q[0].d; last = tx_q[0].l;
      #1;
      check("ready_full", ready, 0);
    end
    fork
      pulse_start();
      begin
        while (tx_q.size() != 0) push_one(tx_q.pop_front(), $urandom_range(gap_max, 0));
        valid = 1'b0;
      end
    join
    while (busy !== 1'b0 && c < 30000) begin
      @(negedge clk);
      c++;
    end
    check("session_end_busy", busy, 0);
    tick(3);
    mon_en = 1'b0;
    verify_session();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; last = 1'b0; err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_io_out", io_out, 0);
    check("rst_io_oeb", oeb, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words, 0);
    check("rst_ready", ready, 1);

    // single word with last
    fill_seq(1, 16'h0001, 1'b0);
    session(0, 0, 1'b0);

    // five words, four preloaded until full
    fill_seq(5, 16'h0010, 1'b0);
    session(4, 0, 1'b1);

    // full FIFO with continuous valid: push and pop coincide
    fill_seq(8, 16'h00A0, 1'b0);
    session(4, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(6, 1);
      fill_seq(n, 16'h0000, 1'b1);
      session($urandom_range((n < DEPTH) ? n : DEPTH, 0), $urandom_range(8, 0), 1'b0);
    end

    // reset while the GAP phase is showing
    fill_seq(2, 16'h0000, 1'b1);
    push_one(tx_q.pop_front(), 0);
    push_one(tx_q.pop_front(), 0);
    pulse_start();
    wait_io_phase("rg_data_seen", 2'b10);
    wait_io_phase("rg_gap_seen", 2'b00);
    check("rg_busy_in_gap", busy, 1);
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rg_io_out", io_out, 0);
    check("rg_busy", busy, 0);
    check("rg_words", words, 0);
    check("rg_ready", ready, 1);
    fill_seq(3, 16'h0000, 1'b1);
    session(1, 2, 1'b0);

    // start with no data ever supplied
    seg_q.delete();
    mon_en = 1'b1;
    pulse_start();
`ifdef GPIO_REPORTER_WATCHDOG_EN
    tick(HOLD + WDOG + 40);
    mon_en = 1'b0;
    seg_k = 0;
    exp_seg("wd_idle0", 2'b00, 16'h0000, 1, BIG);
    exp_seg("wd_wait", 2'b01, 16'h0000, HOLD + WDOG, HOLD + WDOG);
    exp_seg("wd_error", 2'b11, 16'hBEEF, 1, BIG);
    check("wd_busy", busy, 0);
    check("wd_ready", ready, 0);
`else
    tick(HOLD + 400);
    mon_en = 1'b0;
    check("nodata_io", io_out, {2'b01, 16'h0000});
    check("nodata_busy", busy, 1);
`endif
    do_reset();

    // fatal error during a DATA hold
    tx_q.delete();
    fill_seq(3, 16'h0000, 1'b1);
    push_one(tx_q.pop_front(), 0);
    push_one(tx_q.pop_front(), 0);
    pulse_start();
    wait_io_phase("err_data_seen", 2'b10);
    tick(5);
    err = 1'b1;
    @(negedge clk);
    err = 1'b0;
    check("err_busy", busy, 0);
    @(negedge clk);
    check("err_io", io_out, {2'b11, 16'hDEAD});
    valid = 1'b1; data = tx_q[0].d; last = tx_q[0].l;
    #1;
    check("err_ready", ready, 0);
    @(negedge clk);
    valid = 1'b0;
    pulse_start();
    tick(20);
    check("err_sticky_io", io_out, {2'b11, 16'hDEAD});
    check("err_sticky_ready", ready, 0);
    check("err_sticky_busy", busy, 0);
    tx_q.delete();
    do_reset();
    check("post_err_rst_io", io_out, 0);
    check("post_err_rst_ready", ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
